// File: rtl/pad_io_pkg.sv
// Shared helpers and serialiser state encodings for the pad I/O bridge.
// Latency: none (package). Backpressure: n/a.
// IO_PARITY_EN (optional macro) enables the trailing parity beat in the serialiser.
package pad_io_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  function automatic int n_beats(input int total_w, input int beat_w);
    return total_w / beat_w;
  endfunction

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit divides(input int total_w, input int beat_w);
    return (beat_w > 0) && ((total_w % beat_w) == 0);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/pad_io_res_fifo.sv
// Result FIFO, W x DEPTH, power-of-two depth; registered full/empty flags via occupancy count.
// Latency: write at edge E is readable at rd_dat after E. Backpressure: push ignored when full.
module pad_io_res_fifo
  import pad_io_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = cnt_w(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pad_io_bridge.sv
// Pad bridge: packs pad beats into core words (double-buffered) and serialises FIFO'd results.
// Latency: word valid 1 cycle after last beat; first output beat 1 cycle after result push.
// Backpressure: pad_in_ready drops while a finished word waits; core_res_ready = !fifo full. Optional: IO_PARITY_EN.
module pad_io_bridge
  import pad_io_pkg::*;
#(
  parameter int PAD_IN_W  = 16,
  parameter int WORD_W    = 64,
  parameter int PAD_OUT_W = 2,
  parameter int RES_W     = 8,
  parameter int RES_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pad_mode,
  input  logic [PAD_IN_W-1:0]  pad_data_in,
  input  logic                 pad_in_valid,
  output logic                 pad_in_ready,
  output logic [PAD_OUT_W-1:0] pad_data_out,
  output logic                 pad_out_en,
  output logic [WORD_W-1:0]    core_word,
  output logic                 core_mode,
  output logic                 core_word_valid,
  input  logic                 core_word_ready,
  input  logic [RES_W-1:0]     core_res,
  input  logic                 core_res_valid,
  output logic                 core_res_ready
);

  localparam int BEATS  = n_beats(WORD_W, PAD_IN_W);
  localparam int BCW    = cnt_w(BEATS);
  localparam int OBEATS = n_beats(RES_W, PAD_OUT_W);
  localparam int OCW    = cnt_w(OBEATS);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [OCW-1:0] LAST_OB   = OCW'(OBEATS - 1);

  if (!divides(WORD_W, PAD_IN_W)) begin : g_bad_word_w
    $error("pad_io_bridge: WORD_W must be a multiple of PAD_IN_W");
  end
  if (!divides(RES_W, PAD_OUT_W)) begin : g_bad_res_w
    $error("pad_io_bridge: RES_W must be a multiple of PAD_OUT_W");
  end
  if (!is_pow2(RES_DEPTH)) begin : g_bad_depth
    $error("pad_io_bridge: RES_DEPTH must be a power of two >= 2");
  end

  // ---------------- input packer + output word register ----------------
  logic [BCW-1:0]    beat_cnt;
  logic [WORD_W-1:0] pack_buf;
  logic              pack_mode;
  logic              pack_full;
  logic              pack_full_nxt;
  logic [WORD_W-1:0] ow_dat;
  logic              ow_mode;
  logic              ow_vld;
  logic              in_rdy;
  logic              live;
  logic              beat_acc;
  logic              word_done;
  logic              ow_drain;
  logic              ow_free;
  logic [WORD_W-1:0] full_word;
  logic              word_mode;

  assign beat_acc  = pad_in_valid && in_rdy;
  assign word_done = beat_acc && (beat_cnt == LAST_BEAT);
  assign ow_drain  = ow_vld && core_word_ready;
  assign ow_free   = !ow_vld || core_word_ready;
  assign word_mode = (beat_cnt == '0) ? pad_mode : pack_mode;

  // Completed word including the beat arriving this cycle, so it can bypass into ow.
  always_comb begin
    full_word = pack_buf;
    full_word[beat_cnt*PAD_IN_W +: PAD_IN_W] = pad_data_in;
  end

  always_comb begin
    pack_full_nxt = pack_full;
    if (pack_full) pack_full_nxt = !ow_drain;
    else           pack_full_nxt = word_done && !ow_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      pack_buf  <= '0;
      pack_mode <= 1'b0;
      pack_full <= 1'b0;
      ow_dat    <= '0;
      ow_mode   <= 1'b0;
      ow_vld    <= 1'b0;
      in_rdy    <= 1'b0;
      live      <= 1'b0;
    end else begin
      live      <= 1'b1;
      in_rdy    <= !pack_full_nxt;
      pack_full <= pack_full_nxt;
      if (beat_acc) begin
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        pack_buf[beat_cnt*PAD_IN_W +: PAD_IN_W] <= pad_data_in;
        if (beat_cnt == '0) pack_mode <= pad_mode;
      end
      if (pack_full && ow_drain) begin
        ow_dat  <= pack_buf;
        ow_mode <= pack_mode;
      end else if (word_done && ow_free) begin
        ow_dat  <= full_word;
        ow_mode <= word_mode;
        ow_vld  <= 1'b1;
      end else if (ow_drain) begin
        ow_vld  <= 1'b0;
      end
    end
  end

  assign pad_in_ready    = in_rdy;
  assign core_word       = ow_dat;
  assign core_mode       = ow_mode;
  assign core_word_valid = ow_vld;

  // ---------------- result FIFO ----------------
  logic [RES_W-1:0] fifo_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ser_pop;

  assign core_res_ready = live && !fifo_full;

  pad_io_res_fifo #(.W(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (core_res_valid && core_res_ready),
    .push_dat (core_res),
    .pop_rdy  (ser_pop),
    .rd_dat   (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ---------------- serialiser ----------------
  logic [1:0]           ser_state;
  logic [OCW-1:0]       ser_idx;
  logic [RES_W-1:0]     ser_sh;
  logic [PAD_OUT_W-1:0] dout;
  logic                 dout_en;
  logic                 ser_last;
`ifdef IO_PARITY_EN
  logic                 ser_par;
  assign ser_last = (ser_state == S_PARITY);
`else
  assign ser_last = (ser_state == S_SHIFT) && (ser_idx == LAST_OB);
`endif

  // Popping on the final beat keeps back-to-back results gapless.
  assign ser_pop = !fifo_empty && ((ser_state == S_IDLE) || ser_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_state <= S_IDLE;
      ser_idx   <= '0;
      ser_sh    <= '0;
      dout      <= '0;
      dout_en   <= 1'b0;
`ifdef IO_PARITY_EN
      ser_par   <= 1'b0;
`endif
    end else if (ser_pop) begin
      ser_state <= S_SHIFT;
      ser_idx   <= '0;
      ser_sh    <= fifo_dat >> PAD_OUT_W;
      dout      <= fifo_dat[PAD_OUT_W-1:0];
      dout_en   <= 1'b1;
`ifdef IO_PARITY_EN
      ser_par   <= ^fifo_dat;
`endif
    end else begin
      case (ser_state)
        S_SHIFT: begin
          if (ser_idx == LAST_OB) begin
`ifdef IO_PARITY_EN
            ser_state <= S_PARITY;
            dout      <= PAD_OUT_W'(ser_par);
            dout_en   <= 1'b1;
`else
            ser_state <= S_IDLE;
            dout      <= '0;
            dout_en   <= 1'b0;
`endif
          end else begin
            ser_idx <= ser_idx + 1'b1;
            ser_sh  <= ser_sh >> PAD_OUT_W;
            dout    <= ser_sh[PAD_OUT_W-1:0];
            dout_en <= 1'b1;
          end
        end
        S_PARITY: begin
          ser_state <= S_IDLE;
          dout      <= '0;
          dout_en   <= 1'b0;
        end
        default: begin
          ser_state <= S_IDLE;
          dout      <= '0;
          dout_en   <= 1'b0;
        end
      endcase
    end
  end

  assign pad_data_out = dout;
  assign pad_out_en   = dout_en;

endmodule

// File: tb/tb_pad_io_bridge.sv
// Directed bench for pad_io_bridge at default parameters; honours IO_PARITY_EN if defined.
module tb_pad_io_bridge;

`ifdef IO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 4 + PB;

  logic        clk = 1'b0;
  logic        rst;
  logic        pad_mode;
  logic [15:0] pad_data_in;
  logic        pad_in_valid;
  logic        pad_in_ready;
  logic [1:0]  pad_data_out;
  logic        pad_out_en;
  logic [63:0] core_word;
  logic        core_mode;
  logic        core_word_valid;
  logic        core_word_ready;
  logic [7:0]  core_res;
  logic        core_res_valid;
  logic        core_res_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pad_io_bridge dut (
    .clk(clk), .rst(rst), .pad_mode(pad_mode), .pad_data_in(pad_data_in),
    .pad_in_valid(pad_in_valid), .pad_in_ready(pad_in_ready),
    .pad_data_out(pad_data_out), .pad_out_en(pad_out_en),
    .core_word(core_word), .core_mode(core_mode), .core_word_valid(core_word_valid),
    .core_word_ready(core_word_ready), .core_res(core_res),
    .core_res_valid(core_res_valid), .core_res_ready(core_res_ready)
  );

  typedef struct {
    logic [3:0][15:0] beats;
    logic             mode;
    logic [63:0]      word;
  } pack_vec_t;

  typedef struct {
    logic [7:0]      res;
    logic [3:0][1:0] obeats;
    logic            par;
  } ser_vec_t;

  pack_vec_t pv[3];
  ser_vec_t  sv[4];

  // Output beat monitor, sampled on the falling edge.
  logic [1:0] mon_q[$];
  bit         mon_on = 1'b0;
  int         cyc = 0;
  int         mon_first = 0;
  int         mon_last = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_on && pad_out_en) begin
      if (mon_q.size() == 0) mon_first = cyc;
      mon_last = cyc;
      mon_q.push_back(pad_data_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_res(input logic [7:0] v);
    int budget;
    core_res       = v;
    core_res_valid = 1'b1;
    budget = 0;
    while (!core_res_ready && budget < 50) begin
      tick();
      budget++;
    end
    check("push_wait_bound", budget < 50, 1'b1);
    tick();
    core_res_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [15:0] d, input logic m);
    pad_data_in  = d;
    pad_mode     = m;
    pad_in_valid = 1'b1;
    tick();
    pad_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] w;
    logic [7:0]  rw;
    logic [7:0]  fexp[6];
    int          budget;

    pv[0].beats[0] = 16'h1111; pv[0].beats[1] = 16'h2222; pv[0].beats[2] = 16'h3333; pv[0].beats[3] = 16'h4444;
    pv[0].mode = 1'b1; pv[0].word = 64'h4444_3333_2222_1111;
    pv[1].beats[0] = 16'hAAAA; pv[1].beats[1] = 16'h5555; pv[1].beats[2] = 16'h0000; pv[1].beats[3] = 16'hFFFF;
    pv[1].mode = 1'b0; pv[1].word = 64'hFFFF_0000_5555_AAAA;
    pv[2].beats[0] = 16'h1234; pv[2].beats[1] = 16'h5678; pv[2].beats[2] = 16'h9ABC; pv[2].beats[3] = 16'hDEF0;
    pv[2].mode = 1'b1; pv[2].word = 64'hDEF0_9ABC_5678_1234;

    // 0xB4 = 10_11_01_00, 0x01 = 00_00_00_01, 0xE7 = 11_10_01_11, 0x5A = 01_01_10_10
    sv[0].res = 8'hB4; sv[0].obeats[0] = 2'b00; sv[0].obeats[1] = 2'b01; sv[0].obeats[2] = 2'b11; sv[0].obeats[3] = 2'b10; sv[0].par = 1'b0;
    sv[1].res = 8'h01; sv[1].obeats[0] = 2'b01; sv[1].obeats[1] = 2'b00; sv[1].obeats[2] = 2'b00; sv[1].obeats[3] = 2'b00; sv[1].par = 1'b1;
    sv[2].res = 8'hE7; sv[2].obeats[0] = 2'b11; sv[2].obeats[1] = 2'b01; sv[2].obeats[2] = 2'b10; sv[2].obeats[3] = 2'b11; sv[2].par = 1'b0;
    sv[3].res = 8'h5A; sv[3].obeats[0] = 2'b10; sv[3].obeats[1] = 2'b10; sv[3].obeats[2] = 2'b01; sv[3].obeats[3] = 2'b01; sv[3].par = 1'b0;

    fexp[0] = 8'h1B; fexp[1] = 8'h2C; fexp[2] = 8'h3D;
    fexp[3] = 8'h4E; fexp[4] = 8'h5F; fexp[5] = 8'h60;

    rst = 1'b1; pad_mode = 1'b0; pad_data_in = '0; pad_in_valid = 1'b0;
    core_word_ready = 1'b0; core_res = '0; core_res_valid = 1'b0;

    // ---- reset state ----
    tick(); tick();
    check("rst_in_ready", pad_in_ready, 1'b0);
    check("rst_word_valid", core_word_valid, 1'b0);
    check("rst_core_word", core_word, 64'h0);
    check("rst_out_en", pad_out_en, 1'b0);
    check("rst_out_data", pad_data_out, 2'b00);
    check("rst_res_ready", core_res_ready, 1'b0);
    rst = 1'b0;
    check("in_ready_before_edge", pad_in_ready, 1'b0);
    tick();
    check("in_ready_after_rst", pad_in_ready, 1'b1);
    check("res_ready_after_rst", core_res_ready, 1'b1);

    // ---- packing table, gapless with core_word_ready=1 ----
    core_word_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        pad_data_in  = pv[i].beats[k];
        pad_mode     = (k == 0) ? pv[i].mode : ~pv[i].mode;
        pad_in_valid = 1'b1;
        check($sformatf("pk%0d_rdy%0d", i, k), pad_in_ready, 1'b1);
        tick();
        if (k < 3) check($sformatf("pk%0d_novalid%0d", i, k), core_word_valid, 1'b0);
      end
      check($sformatf("pk%0d_valid", i), core_word_valid, 1'b1);
      check($sformatf("pk%0d_word", i), core_word, pv[i].word);
      check($sformatf("pk%0d_mode", i), core_mode, pv[i].mode);
    end
    pad_in_valid = 1'b0;
    tick();
    check("pk_drained", core_word_valid, 1'b0);

    // ---- backpressure: two words held, then released in order ----
    core_word_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      pad_data_in  = 16'h0100 * 16'(k + 1) + 16'(k + 1);
      pad_mode     = (k == 0) || (k == 5);
      pad_in_valid = 1'b1;
      check($sformatf("bp_rdy%0d", k), pad_in_ready, 1'b1);
      tick();
    end
    pad_in_valid = 1'b0;
    check("bp_rdy_low", pad_in_ready, 1'b0);
    tick(); tick();
    check("bp_hold_valid", core_word_valid, 1'b1);
    check("bp_hold_word", core_word, 64'h0404_0303_0202_0101);
    check("bp_hold_mode", core_mode, 1'b1);
    check("bp_rdy_still_low", pad_in_ready, 1'b0);
    core_word_ready = 1'b1;
    tick();
    check("bp_w2_valid", core_word_valid, 1'b1);
    check("bp_w2_word", core_word, 64'h0808_0707_0606_0505);
    check("bp_w2_mode", core_mode, 1'b0);
    check("bp_rdy_back", pad_in_ready, 1'b1);
    tick();
    check("bp_drained", core_word_valid, 1'b0);

    // ---- serialiser table ----
    for (int i = 0; i < 4; i++) begin
      push_res(sv[i].res);
      check($sformatf("ser%0d_lat", i), pad_out_en, 1'b0);
      for (int b = 0; b < NB; b++) begin
        tick();
        check($sformatf("ser%0d_en%0d", i, b), pad_out_en, 1'b1);
        if (b < 4) check($sformatf("ser%0d_dat%0d", i, b), pad_data_out, sv[i].obeats[b]);
        else       check($sformatf("ser%0d_par", i), pad_data_out, {1'b0, sv[i].par});
      end
      tick();
      check($sformatf("ser%0d_en_off", i), pad_out_en, 1'b0);
      check($sformatf("ser%0d_dat_off", i), pad_data_out, 2'b00);
    end

    // ---- FIFO full, gapless back-to-back output ----
    mon_q.delete();
    mon_on = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_res(fexp[i]);
      if (i == 4) check("ff_res_ready_low", core_res_ready, 1'b0);
    end
    budget = 0;
    while (mon_q.size() < 6 * NB && budget < 200) begin
      tick();
      budget++;
    end
    tick(); tick();
    mon_on = 1'b0;
    check("ff_beat_count", mon_q.size(), 6 * NB);
    check("ff_gapless", mon_last - mon_first + 1, 6 * NB);
    if (mon_q.size() == 6 * NB) begin
      for (int i = 0; i < 6; i++) begin
        rw = '0;
        for (int b = 0; b < 4; b++) rw[b*2 +: 2] = mon_q[i*NB + b];
        check($sformatf("ff_word%0d", i), rw, fexp[i]);
        if (PB == 1) check($sformatf("ff_par%0d", i), mon_q[i*NB + 4], {1'b0, ^fexp[i]});
      end
    end
    check("ff_res_ready_back", core_res_ready, 1'b1);

    // ---- reset mid-operation ----
    push_res(8'hFF);
    drive_beat(16'hDEAD, 1'b1);
    drive_beat(16'hBEEF, 1'b1);
    check("mr_out_active", pad_out_en, 1'b1);
    rst = 1'b1;
    tick();
    check("mr_out_en_cut", pad_out_en, 1'b0);
    check("mr_out_dat_cut", pad_data_out, 2'b00);
    check("mr_in_ready_low", pad_in_ready, 1'b0);
    check("mr_res_ready_low", core_res_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("mr_in_ready_back", pad_in_ready, 1'b1);
    check("mr_out_quiet", pad_out_en, 1'b0);
    drive_beat(16'h0A0A, 1'b0);
    drive_beat(16'h0B0B, 1'b1);
    check("mr_no_early_word", core_word_valid, 1'b0);
    drive_beat(16'h0C0C, 1'b1);
    check("mr_no_early_word2", core_word_valid, 1'b0);
    drive_beat(16'h0D0D, 1'b1);
    w = core_word;
    check("mr_word_valid", core_word_valid, 1'b1);
    check("mr_word", w, 64'h0D0D_0C0C_0B0B_0A0A);
    check("mr_mode", core_mode, 1'b0);
    check("mr_out_still_quiet", pad_out_en, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
